// File: rtl/find_emax_pkg.sv
// Shared block-floating-point helpers: block geometry and double-precision field widths.
package find_emax_pkg;

  localparam int DP_FP_E = 11;
  localparam int DP_FP_F = 52;

  function automatic int fpblk_sz(input int dim);
    return 1 << (2 * dim);
  endfunction

  function automatic int fpblk_beats(input int dim, input int lanes);
    return fpblk_sz(dim) / lanes;
  endfunction

endpackage

// File: rtl/find_emax_reduce.sv
// Combinational maximum of the exponent fields across all lanes of one beat.
// Build with FIND_EMAX_IGNORE_SPECIAL_EN to treat all-ones (Inf/NaN) exponents as 0.
module find_emax_reduce
  import find_emax_pkg::*;
#(
  parameter int LANES = 1,
  parameter int FP    = 64,
  parameter int FP_E  = 11,
  parameter int FP_F  = 52
) (
  input  logic [LANES*FP-1:0] i_data,
  output logic [FP_E-1:0]     o_max
);
  // Heap-ordered tree: leaves at LANES-1.., node n combines 2n+1 and 2n+2.
  logic [FP_E-1:0] w_node [2*LANES-1];
  logic [LANES-1:0] w_unused_lane;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_leaf
      logic [FP_E-1:0] w_exp;
      assign w_exp = i_data[gi*FP + FP_F +: FP_E];
      assign w_unused_lane[gi] = ^{i_data[gi*FP + FP - 1], i_data[gi*FP +: FP_F]};
`ifdef FIND_EMAX_IGNORE_SPECIAL_EN
      assign w_node[LANES-1+gi] = (&w_exp) ? '0 : w_exp;
`else
      assign w_node[LANES-1+gi] = w_exp;
`endif
    end
    for (gi = 0; gi < LANES - 1; gi++) begin : g_node
      assign w_node[gi] = (w_node[2*gi+1] > w_node[2*gi+2]) ? w_node[2*gi+1] : w_node[2*gi+2];
    end
  endgenerate

  assign o_max = w_node[0];
endmodule

// File: rtl/rvfifo_cc.sv
// Single-clock ready/valid FIFO. The output word reads zero while the FIFO is empty.
module rvfifo_cc #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign s_ready = (r_count != CNTW'(DEPTH));
  assign m_valid = (r_count != '0);
  assign m_data  = m_valid ? r_mem[r_rd_ptr] : '0;
  assign w_push  = s_valid && s_ready;
  assign w_pop   = m_valid && m_ready;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNTW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNTW'(1);
    end
  end
endmodule

// File: rtl/find_emax_lanes.sv
// Block exponent finder: forwards beats through a FIFO and emits one max-exponent token per block.
// Optional build macro: FIND_EMAX_IGNORE_SPECIAL_EN (exclude Inf/NaN exponents from the maximum).
module find_emax_lanes
  import find_emax_pkg::*;
#(
  parameter int FP_E       = DP_FP_E,
  parameter int FP_F       = DP_FP_F,
  parameter int DIM        = 2,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 2 * fpblk_sz(DIM) / LANES + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES*(1+FP_E+FP_F)-1:0] s_fp_data,
  input  logic                         s_fp_valid,
  output logic                         s_fp_ready,
  output logic [LANES*(1+FP_E+FP_F)-1:0] m_fp_data,
  output logic                         m_fp_last,
  output logic                         m_fp_valid,
  input  logic                         m_fp_ready,
  output logic [FP_E-1:0]              m_ex_data,
  output logic                         m_ex_valid,
  input  logic                         m_ex_ready
);
  localparam int FP    = 1 + FP_E + FP_F;
  localparam int BEATS = fpblk_beats(DIM, LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  logic [CW-1:0]       r_cnt;
  logic [FP_E-1:0]     r_acc;
  logic [FP_E-1:0]     r_ex_data;
  logic                r_ex_valid;
  logic [FP_E-1:0]     w_beat_max;
  logic [FP_E-1:0]     w_acc_max;
  logic [FP_E-1:0]     w_block_max;
  logic                w_last;
  logic                w_ex_free;
  logic                w_fifo_ready;
  logic                w_accept;
  logic [LANES*FP:0]   w_fifo_out;

  find_emax_reduce #(
    .LANES(LANES),
    .FP   (FP),
    .FP_E (FP_E),
    .FP_F (FP_F)
  ) u_reduce (
    .i_data(s_fp_data),
    .o_max (w_beat_max)
  );

  assign w_last      = (r_cnt == LAST_IDX);
  assign w_ex_free   = !r_ex_valid || m_ex_ready;
  // The last beat may only enter when its token has somewhere to go.
  assign s_fp_ready  = reset && w_fifo_ready && (!w_last || w_ex_free);
  assign w_accept    = s_fp_valid && s_fp_ready;
  assign w_acc_max   = (r_acc > w_beat_max) ? r_acc : w_beat_max;
  assign w_block_max = (BEATS == 1) ? w_beat_max : w_acc_max;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_ex_data  <= '0;
      r_ex_valid <= 1'b0;
    end else begin
      if (w_accept && w_last) begin
        r_cnt      <= '0;
        r_acc      <= '0;
        r_ex_data  <= w_block_max;
        r_ex_valid <= 1'b1;
      end else begin
        if (w_accept) begin
          r_cnt <= r_cnt + CW'(1);
          r_acc <= (r_cnt == '0) ? w_beat_max : w_acc_max;
        end
        if (r_ex_valid && m_ex_ready) r_ex_valid <= 1'b0;
      end
    end
  end

  assign m_ex_data  = r_ex_data;
  assign m_ex_valid = r_ex_valid;

  rvfifo_cc #(
    .WIDTH(LANES*FP + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .s_data ({w_last, s_fp_data}),
    .s_valid(w_accept),
    .s_ready(w_fifo_ready),
    .m_data (w_fifo_out),
    .m_valid(m_fp_valid),
    .m_ready(m_fp_ready)
  );

  assign m_fp_last = w_fifo_out[LANES*FP];
  assign m_fp_data = w_fifo_out[LANES*FP-1:0];
endmodule

// File: doc/find_emax_lanes.md
# find_emax_lanes

Multi-lane, fully parametrised block-floating-point exponent finder.
- Accepts LANES IEEE-style floats per beat and groups them into blocks of 4^DIM values.
- Forwards every beat unchanged through an internal data FIFO, tagged with a block-last flag.
- Emits one maximum-exponent token per block on a separate stream.
- Sits in front of the block-alignment/shift stage of the compression datapath.

## Interface
- FP_E, 11, exponent width
- FP_F, 52, fraction width
- DIM, 2, block dimension; block size BLK = 1 << (2*DIM) values
- LANES, 1, floats per beat; power of two, 1 ≤ LANES ≤ BLK
- FIFO_DEPTH, 2*BLK/LANES+1, data FIFO depth in beats; must be ≥ BLK/LANES+1
- Derived localparams: FP = 1+FP_E+FP_F; BEATS = BLK/LANES; CW = max(1, $clog2(BEATS))

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- s_fp_data  in  LANES*FP  input beat; lane i at [i*FP +: FP], packed {sign, expo, frac}
- s_fp_valid  in  1  input valid
- s_fp_ready  out  1  input ready
- m_fp_data  out  LANES*FP  forwarded beat
- m_fp_last  out  1  high on the final beat of a block
- m_fp_valid  out  1  data output valid
- m_fp_ready  in  1  data output ready
- m_ex_data  out  FP_E  block maximum exponent
- m_ex_valid  out  1  exponent valid
- m_ex_ready  in  1  exponent ready

## Operation
- Beat counter `cnt` (CW bits) holds the beat index within the current block.
  - `last = (cnt == BEATS-1)`.
- `beat_max` is the combinational unsigned maximum of the LANES exponent fields of s_fp_data.
- Accumulator `acc` (FP_E bits) holds the running block maximum over accepted beats.
- Accept condition:
  - `ex_free = !m_ex_valid || m_ex_ready`.
  - `s_fp_ready = reset && fifo_ready && (!last || ex_free)`.
  - A beat is accepted when `s_fp_valid && s_fp_ready`.
  - s_fp_ready does not depend on s_fp_valid.
- On an accepted non-last beat:
  - `cnt <= cnt+1`.
  - `acc <= (cnt==0) ? beat_max : max(acc, beat_max)`.
- On an accepted last beat:
  - `cnt <= 0`.
  - `acc <= 0`.
  - `m_ex_data <= max(acc, beat_max)`, or `beat_max` when BEATS == 1.
  - `m_ex_valid <= 1`.
- Exponent output register:
  - On `m_ex_valid && m_ex_ready` with no simultaneous load: `m_ex_valid <= 0`; m_ex_data holds its value.
  - Simultaneous consume and load: the new value is loaded and m_ex_valid stays 1.
- Every accepted beat is pushed into the FIFO as `{last, s_fp_data}`.
  - The FIFO outputs drive m_fp_last, m_fp_data and m_fp_valid under standard ready/valid rules.
- Blocks are fully independent; no exponent carries over between blocks.
- Comparisons are unsigned; no sign or fraction bits participate.

## Timing
- Reset (reset low at a clk edge):
  - cnt, acc, m_ex_data = 0; m_ex_valid = 0.
  - FIFO is emptied: m_fp_valid = 0, m_fp_last = 0, m_fp_data = 0.
  - s_fp_ready = 0 while reset is low.
- Reset mid-block discards the partial block, its FIFO contents and any pending exponent token.
- Exponent latency: m_ex_valid rises on the clk edge that accepts the last beat of the block, i.e. visible 1 cycle after acceptance.
- Data latency follows the FIFO: minimum 1 cycle.
- Throughput: 1 beat per cycle while both outputs drain.
  - Only the last beat of a block stalls on a pending, unconsumed exponent token.
- FIFO full: s_fp_ready = 0 and the counter holds. FIFO empty: m_fp_valid = 0.
- An output valid never drops without its ready.
- Output data is stable while valid is high and ready is low.

## Configuration
- Macro FIND_EMAX_IGNORE_SPECIAL_EN.
- Defined:
  - Lanes whose exponent is all-ones (Inf/NaN) contribute 0 to beat_max.
  - A block consisting only of specials reports 0.
- Undefined: all exponents participate, so all-ones wins the maximum.
- Data forwarding is identical in both builds.

## Structure
- Shared package find_emax_pkg:
  - function fpblk_sz(dim) returning 1 << 2*dim;
  - function fpblk_beats(dim, lanes);
  - localparam for the default FP_E/FP_F of double precision.
- Sub-module find_emax_reduce:
  - parameters LANES, FP, FP_E, FP_F;
  - combinational lane-maximum tree with the special-exponent mask under the macro.
- The data queue reuses the existing rvfifo_cc, width LANES*FP+1; no new FIFO RTL.

## Test plan
All scenarios use FP_E=11, FP_F=52, DIM=2 and LANES=4 (4 beats per block) unless noted.

- Reset: hold reset low for 3 cycles with s_fp_valid=1 -> s_fp_ready, m_fp_valid, m_ex_valid and m_ex_data are all 0.
- Single block: exponents 0x3FF everywhere except 0x405 at lane 2 of beat 3 -> m_ex_data=0x405 one cycle after beat 3 is accepted; m_fp_last=1 only on the 4th output beat; data is bit-exact.
- Back-to-back blocks with both readies high:
  - block A max is 0x410, block B max is 0x401;
  - -> tokens 0x410 then 0x401, no input bubbles over 8 cycles.
- Exponent backpressure, m_ex_ready=0:
  - block B beats 0–2 are accepted; beat 3 sees s_fp_ready=0 until m_ex_ready pulses;
  - it is then accepted in the same cycle the token is consumed.
- Reset after 2 beats of a block, then a fresh block with max 0x3F0 -> output is 0x3F0; no stale data reaches m_fp.
- Macro test: block with one 0x7FF exponent and others 0x400.
  - -> 0x400 with FIND_EMAX_IGNORE_SPECIAL_EN defined, 0x7FF without.
  - An all-0x7FF block reports 0 with the macro defined.
  - Repeat the single-block case with LANES=1 (16 beats).
